// File: rtl/lfsr_prng.sv
// -----------------------------------------------------------------------------
// lfsr_prng
//
// Pseudo-random word generator built on a Fibonacci LFSR of parameterised
// width and tap mask. Words are handed out through a valid/ready handshake.
// Each accepted draw advances the LFSR by STEPS shifts. An all-zero seed is
// replaced by DEFAULT_SEED so the register can never lock up. A one-cycle wrap
// pulse marks the point where the sequence returns to the loaded seed.
//
// Parameters
//   WIDTH        LFSR width in bits (3..32)
//   TAPS         tap mask; bit i set means state[i] feeds the XOR
//   STEPS        LFSR shifts per accepted draw (1..WIDTH)
//   DEFAULT_SEED reset state, also used in place of an all-zero seed (non-zero)
//
// Ports
//   clk        i  clock, rising edge
//   rst_n      i  asynchronous active-low reset
//   en         i  generator enable; gates new draws only
//   load_seed  i  load seed this cycle (highest priority)
//   seed       i  seed value
//   out_valid  o  rand_out holds an unconsumed word
//   out_ready  i  consumer accepts rand_out
//   rand_out   o  registered random word
//   wrap       o  one-cycle pulse: the state has returned to the loaded seed
// -----------------------------------------------------------------------------
module lfsr_prng #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
    parameter int unsigned      STEPS        = 1,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load_seed,
    input  logic [WIDTH-1:0] seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rand_out,
    output logic             wrap
);

    // One Fibonacci shift: the feedback bit enters at the LSB.
    function automatic logic [WIDTH-1:0] lfsr_shift(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] rand_q, rand_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] seed_eff;
    logic             draw;

    // STEPS shifts unrolled into one combinational cone.
    always_comb begin
        stepped = state_q;
        for (int i = 0; i < int'(STEPS); i++) begin
            stepped = lfsr_shift(stepped);
        end
    end

    // A zero seed would freeze the LFSR; substitute the default instead.
    assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;

    // A new word is produced when the output slot is empty or being emptied.
    assign draw = en && !load_seed && (!valid_q || out_ready);

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        rand_d  = rand_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        if (load_seed) begin
            // Load flushes the held word even if it is accepted this cycle.
            state_d = seed_eff;
            seed_d  = seed_eff;
            valid_d = 1'b0;
        end else if (draw) begin
            rand_d  = state_q;
            valid_d = 1'b1;
            state_d = stepped;
            wrap_d  = (stepped == seed_q);
        end else if (valid_q && out_ready) begin
            // Consumer took the word while the generator is disabled.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DEFAULT_SEED;
            seed_q  <= DEFAULT_SEED;
            rand_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            rand_q  <= rand_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out_valid = valid_q;
    assign rand_out  = rand_q;
    assign wrap      = wrap_q;

endmodule

// File: doc/lfsr_prng.md
# lfsr_prng

Parametrised pseudo-random word generator built on a Fibonacci LFSR of configurable width and tap polynomial. It adds a valid/ready output handshake, multi-step advance per draw, zero-seed lock-up protection and a sequence-wrap indicator. It sits between a seed/config source and any consumer that pulls random words at its own rate, such as test-pattern generators or scramblers.

## Interface
- WIDTH, 8: LFSR state width in bits, legal range 3..32.
- TAPS, 8'hB8: tap mask; bit i set means state[i] feeds the XOR. The default selects taps 7, 5, 4, 3.
- STEPS, 1: LFSR shifts per accepted draw, legal range 1..WIDTH.
- DEFAULT_SEED, 1: state loaded on reset and substituted for an all-zero seed; must be non-zero.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  generator enable; gates new draws only.
- load_seed  input  1  load `seed` this cycle.
- seed  input  WIDTH  seed value.
- out_valid  output  1  rand_out holds an unconsumed word.
- out_ready  input  1  consumer accepts rand_out.
- rand_out  output  WIDTH  registered random word.
- wrap  output  1  one-cycle pulse: the state has returned to the loaded seed.

## Operation
- Single shift: fb = XOR of (state AND TAPS); next = {state[WIDTH-2:0], fb}.
- A draw applies STEPS single shifts combinationally in one cycle.
- Seed register seed_q holds the last loaded seed, or DEFAULT_SEED after reset. It is the wrap reference.
- Load, which has the highest priority:
  - state <= seed, or DEFAULT_SEED if seed == 0; seed_q gets the same value.
  - out_valid <= 0, which flushes the held word even if it is being accepted this cycle.
  - wrap <= 0.
- Draw condition: en && !load_seed && (!out_valid || out_ready).
  - rand_out <= current state.
  - out_valid <= 1.
  - state <= STEPS-shifted state.
- Accept without draw: en=0, out_valid && out_ready gives out_valid <= 0.
- Hold: out_valid && !out_ready keeps rand_out and state stable, regardless of en.
- wrap <= 1 for one cycle when a draw occurs and the STEPS-shifted state == seed_q; otherwise wrap <= 0.
- All-zero state is unreachable: reset, load and DEFAULT_SEED are all non-zero.
- The sequence period for a maximal-length TAPS with STEPS coprime to 2^WIDTH-1 is 2^WIDTH-1 draws.

## Timing
- Reset asserted, taking effect immediately:
  - state = DEFAULT_SEED, seed_q = DEFAULT_SEED.
  - out_valid = 0, rand_out = 0, wrap = 0.
- First edge after reset release with en=1: out_valid=1 and rand_out=DEFAULT_SEED.
- Throughput: one word per cycle while en=1 and out_ready=1 (full-rate streaming, no bubbles).
- Load-to-first-word latency: load at edge N, first draw at edge N+1, so rand_out = seed is visible after edge N+1.
- rand_out and out_valid change only on clk edges or reset; no combinational path from out_ready to outputs.
- load_seed together with out_ready=1: the held word counts as consumed and is discarded; no new word that cycle.
- Reset mid-stream discards the held word and restores the reset values above.

## Test plan
- Reset and first draw:
  - Stimulus: reset, release, en=1, out_ready=1.
  - Response: out_valid rises after 1 edge; rand_out sequence 0x01, 0x02, 0x04, 0x08, 0x11 with default parameters.
- Backpressure:
  - Stimulus: seed 0x01; out_ready=0 for 5 cycles after the first word.
  - Response: rand_out stays 0x01 with out_valid=1; once out_ready=1 the next words are 0x02, 0x04 with no skipped values.
- Zero seed:
  - Stimulus: load_seed=1 with seed=0x00.
  - Response: first word 0x01 (DEFAULT_SEED); the stream never reaches 0x00 over 300 draws.
- Full period and wrap:
  - Stimulus: seed 0x5A, streaming at full rate.
  - Response: wrap pulses exactly once every 255 draws; the word after each pulse is 0x5A; all 255 non-zero values appear once per period.
- STEPS=3 configuration:
  - Stimulus: seed 0x01.
  - Response: words 0x01, 0x08, 0x47, matching every third value of the STEPS=1 sequence.
- Load mid-stream and async reset:
  - Stimulus: load 0x80 while out_valid=1 and out_ready=1, then assert rst_n low mid-cycle during streaming.
  - Response: after the load, out_valid=0 for one cycle, then 0x80 is emitted. On reset, out_valid drops immediately without waiting for an edge, and restart gives 0x01.
